polar_encoder_iter: RTL
=======================

Name: polar_encoder_iter

Overview:
Parametrised, handshaked polar encoder for an (N,K) code.
- Maps K information bits into the non-frozen positions of an N-bit u-vector; frozen positions are zero.
- Computes x = u·F^(⊗n), with F = [[1,0],[1,1]], natural order, no bit-reversal.
- Executes one butterfly stage per clock over n = log2(N) stages.
- Sits between the CRC/segmentation stage and the rate-matcher. Uses valid/ready on both sides with full backpressure.

Parameters:
- N, 8: code length; power of two, 2..1024.
- K, 4: information bits per block; 1..N.
- FROZEN_MASK, 8'b0001_0111: N-bit mask; bit i = 1 means position i is frozen. Popcount of zeros must equal K.
- LOG2N, 3: log2(N); must be consistent with N.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input block valid
- in_ready  out  1  encoder can accept a block
- data_in  in  K  information bits
- out_valid  out  1  encoded block valid
- out_ready  in  1  downstream accepts the block
- data_out  out  N  codeword x
- busy  out  1  high in STAGE or DONE
- blk_cnt  out  16  completed-block counter

Behaviour:
- Reset values (asserted on any rst=1 clock edge): state=IDLE, in_ready=1, out_valid=0, data_out=0, busy=0, blk_cnt=0, stage counter=0, u register=0.
- Reset mid-operation aborts the block in flight; no partial output is emitted.
- Bit mapping: data_in[0] goes to the lowest-index non-frozen position, ascending from there. Frozen positions load 0.
- Default parameters give info positions 3,5,6,7 ← data_in[0..3].
- Butterfly stage s (0..LOG2N-1): for every i with bit s of i = 0, u[i] <= u[i] ^ u[i + 2^s]. All XORs in a stage use the previous-cycle u.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, load the mapped u and clear the stage counter; go to STAGE.
  - STAGE: in_ready=0. Apply stage s = stage counter, then increment it. When s = LOG2N-1, copy the stage result into data_out, set out_valid=1, go to DONE.
  - DONE: out_valid=1; data_out and out_valid held stable until out_ready.
    - out_ready=1 and in_valid=0: blk_cnt++, go to IDLE.
    - out_ready=1 and in_valid=1 (in_ready is combinationally 1 here): accept the new block in the same cycle, blk_cnt++, go to STAGE.
    - out_ready=0: stay in DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Latency: out_valid rises LOG2N clocks after the acceptance edge; 3 clocks for N=8.
- Peak throughput: one block per LOG2N+1 cycles with out_ready held high and back-to-back input.
- data_out changes only on the final-stage edge. Between blocks it keeps the last codeword.
- blk_cnt wraps from 0xFFFF to 0.
- data_in is sampled only on the acceptance edge; later changes are ignored.
- N=2 (LOG2N=1): a single STAGE cycle.

Test Plan:
- Reset, then data_in=4'b0001 with in_valid pulse → out_valid 3 clocks after acceptance, data_out=8'h0F, blk_cnt=1 after out_ready.
- data_in=4'b0010 → 8'h33. data_in=4'b0100 → 8'h55. data_in=4'b1000 → 8'hFF. data_in=4'b1111 → XOR of the four = 8'h96.
- Backpressure: out_ready=0 for 10 cycles after out_valid, then in_valid held with new data → data_out/out_valid stable throughout, in_ready=0 until out_ready=1, blk_cnt increments once.
- Back-to-back: out_ready=1, in_valid=1 continuously with alternating 4'b0001/4'b1000 → accept every 4 cycles, outputs 0F,FF,0F,…, no drops or duplicates.
- Reset asserted during STAGE (second stage cycle) → next cycle out_valid=0, data_out=0, blk_cnt=0, in_ready=1, no output for the aborted block.
- Parameter sweep N=16 K=8 with a chosen mask → random data_in matches a reference model of u·F^(⊗4); 1000 blocks, plus a blk_cnt wrap check by forcing the counter near 0xFFFF.

Source files
------------

// File: rtl/polar_encoder_iter_if.sv
// Block-level valid/ready bundle between segmentation, polar encoder and rate-matcher.
// The encoder sits on the slave side; its neighbours use the master view.
interface polar_encoder_iter_if #(
    parameter int N = 8,
    parameter int K = 4
) ();
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] data_out;

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out
    );

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out
    );
endinterface

// File: rtl/polar_encoder_iter.sv
// Iterative (N,K) polar encoder: x = u * F^(kron n), one butterfly stage per clock.
// Info bits fill the non-frozen positions in ascending order; frozen positions are zero.
module polar_encoder_iter #(
    parameter int           N           = 8,
    parameter int           K           = 4,
    parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111,
    parameter int           LOG2N       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    polar_encoder_iter_if.slave  bus,
    output logic                 busy,
    output logic [15:0]          blk_cnt
);

    localparam int SW = (LOG2N > 0) ? LOG2N : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STAGE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SW-1:0] LAST = SW'(LOG2N - 1);

    function automatic logic [N-1:0] map_info(input logic [K-1:0] d);
        int j;
        map_info = '0;
        j = 0;
        for (int i = 0; i < N; i++) begin
            if (!FROZEN_MASK[i]) begin
                if (j < K) map_info[i] = d[j];
                j++;
            end
        end
    endfunction

    // Stage s pairs i with i + 2^s; the lower index absorbs the XOR.
    function automatic logic [N-1:0] butterfly(
        input logic [N-1:0]  u,
        input logic [SW-1:0] s
    );
        butterfly = u;
        for (int i = 0; i < N; i++) begin
            if (((i >> s) & 1) == 0) begin
                butterfly[i] = u[i] ^ u[i + (1 << s)];
            end
        end
    endfunction

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  u_q, u_d;
    logic [SW-1:0] stg_q, stg_d;
    logic [N-1:0]  dout_q, dout_d;
    logic [15:0]   blk_cnt_q, blk_cnt_d;

    logic          in_ready;
    logic [N-1:0]  u_map;
    logic [N-1:0]  u_stage;

    assign in_ready = (state_q == S_IDLE) ||
                      ((state_q == S_DONE) && bus.out_ready);

    assign u_map   = map_info(bus.data_in);
    assign u_stage = butterfly(u_q, stg_q);

    always_comb begin
        state_d   = state_q;
        u_d       = u_q;
        stg_d     = stg_q;
        dout_d    = dout_q;
        blk_cnt_d = blk_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    u_d     = u_map;
                    stg_d   = '0;
                    state_d = S_STAGE;
                end
            end
            S_STAGE: begin
                u_d   = u_stage;
                stg_d = stg_q + 1'b1;
                if (stg_q == LAST) begin
                    dout_d  = u_stage;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    blk_cnt_d = blk_cnt_q + 16'd1;
                    state_d   = S_IDLE;
                    // Same-cycle hand-over keeps back-to-back blocks at LOG2N+1 cycles.
                    if (bus.in_valid) begin
                        u_d     = u_map;
                        stg_d   = '0;
                        state_d = S_STAGE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            u_q       <= '0;
            stg_q     <= '0;
            dout_q    <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            u_q       <= u_d;
            stg_q     <= stg_d;
            dout_q    <= dout_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.data_out  = dout_q;
    assign busy          = (state_q != S_IDLE);
    assign blk_cnt       = blk_cnt_q;

endmodule
